module_leds_rgb_pwm: RTL and testbench

- Parametrised successor to the single 3-bit RGB colour driver. Drives N_LEDS RGB LEDs, each with independent 8-bit-class PWM intensity per colour channel and a per-LED mode (off / steady / blink).
- Sits on the peripheral bus beside the other LED/display peripherals.
- Software writes one 32-bit word per LED. New settings take effect only at PWM frame boundaries, so outputs never glitch mid-frame.

---
 rtl/module_leds_rgb_pwm.sv | 132 +++++++++++++
 tb/tb_module_leds_rgb_pwm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/module_leds_rgb_pwm.sv
// module_leds_rgb_pwm
//   Multi-LED RGB PWM driver. Each LED has a software-visible shadow word
//   and an active copy used by the PWM compare. Active copies only reload
//   at PWM frame boundaries, so outputs never change settings mid-frame.
//
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   we_i       write strobe (one cycle per write)
//   addr_i     LED index; indices >= N_LEDS are ignored / read as 0
//   data_i     {mode[25:24], red[23:16], green[15:8], blue[7:0]}
//   rd_data_o  registered shadow word of LED addr_i
//   rgb_o      LED k on bits [3k+2:3k] = {R,G,B}, registered
//   frame_o    one-cycle pulse after each PWM frame boundary
module module_leds_rgb_pwm #(
  parameter int N_LEDS       = 2,
  parameter int PWM_BITS     = 8,
  parameter int PRESC        = 39,
  parameter int BLINK_FRAMES = 61
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [2:0]            addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           rd_data_o,
  output logic [3*N_LEDS-1:0]   rgb_o,
  output logic                  frame_o
);

  localparam int PRESC_W = (PRESC > 0) ? $clog2(PRESC + 1) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [3:0]         N_LEDS_L  = 4'(N_LEDS);
  localparam logic [7:0]         DUTY_MASK = 8'((32'd1 << PWM_BITS) - 32'd1);
  // Only the mode bits and the in-range duty bits are ever stored.
  localparam logic [31:0]        WORD_MASK = {8'h03, DUTY_MASK, DUTY_MASK, DUTY_MASK};

  logic [PRESC_W-1:0]  presc_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                frame_end;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_phase;

  logic [31:0]         shadow [N_LEDS];
  logic [1:0]          act_mode [N_LEDS];
  logic [PWM_BITS-1:0] act_r [N_LEDS];
  logic [PWM_BITS-1:0] act_g [N_LEDS];
  logic [PWM_BITS-1:0] act_b [N_LEDS];

  logic                wr_hit;
  logic [31:0]         wdata;
  logic [31:0]         rd_next;
  logic [3*N_LEDS-1:0] rgb_next;

  always_comb begin
    tick      = (presc_cnt == PRESC_MAX);
    frame_end = tick && (pwm_cnt == '1);
    wr_hit    = we_i && ({1'b0, addr_i} < N_LEDS_L);
    wdata     = data_i & WORD_MASK;
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned k = 0; k < N_LEDS; k++) begin
      if (addr_i == 3'(k)) rd_next = shadow[k];
    end
  end

  always_comb begin
    rgb_next = '0;
    for (int unsigned k = 0; k < N_LEDS; k++) begin
      logic en;
      en = (act_mode[k] == 2'b01) || ((act_mode[k] == 2'b10) && blink_phase);
      rgb_next[3*k +: 3] = {en && (pwm_cnt < act_r[k]),
                            en && (pwm_cnt < act_g[k]),
                            en && (pwm_cnt < act_b[k])};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_o     <= 1'b0;
      rd_data_o   <= '0;
      rgb_o       <= '0;
      for (int unsigned k = 0; k < N_LEDS; k++) begin
        shadow[k]   <= '0;
        act_mode[k] <= '0;
        act_r[k]    <= '0;
        act_g[k]    <= '0;
        act_b[k]    <= '0;
      end
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      frame_o   <= frame_end;
      rd_data_o <= rd_next;
      rgb_o     <= rgb_next;

      if (frame_end) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      for (int unsigned k = 0; k < N_LEDS; k++) begin
        logic wr_k;
        wr_k = wr_hit && (addr_i == 3'(k));
        if (wr_k) shadow[k] <= wdata;
        // A write landing on the frame boundary is forwarded straight into
        // the active copy so the new frame already uses it.
        if (frame_end) begin
          act_mode[k] <= wr_k ? wdata[25:24]              : shadow[k][25:24];
          act_r[k]    <= wr_k ? wdata[16 +: PWM_BITS]     : shadow[k][16 +: PWM_BITS];
          act_g[k]    <= wr_k ? wdata[8 +: PWM_BITS]      : shadow[k][8 +: PWM_BITS];
          act_b[k]    <= wr_k ? wdata[0 +: PWM_BITS]      : shadow[k][0 +: PWM_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_module_leds_rgb_pwm.sv
module tb_module_leds_rgb_pwm;

  localparam int N         = 2;
  localparam int B         = 8;
  localparam int P         = 0;
  localparam int BF        = 2;
  localparam int FRAME_CYC = (P + 1) * (1 << B);
  localparam int DMAX      = (1 << B) - 1;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            we_i = 1'b0;
  logic [2:0]      addr_i = '0;
  logic [31:0]     data_i = '0;
  logic [31:0]     rd_data_o;
  logic [3*N-1:0]  rgb_o;
  logic            frame_o;

  always #5 clk = ~clk;

  module_leds_rgb_pwm #(
    .N_LEDS(N), .PWM_BITS(B), .PRESC(P), .BLINK_FRAMES(BF)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .rd_data_o(rd_data_o), .rgb_o(rgb_o), .frame_o(frame_o)
  );

  typedef struct packed {
    logic [3*N-1:0] rgb;
    logic           frm;
    logic [31:0]    rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned mcyc = 0;   // clock edges since the last reset edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stored(input logic [31:0] d);
    logic [31:0] w;
    w = '0;
    w[25:24] = d[25:24];
    w[23:16] = 8'(int'(d[23:16]) & DMAX);
    w[15:8]  = 8'(int'(d[15:8])  & DMAX);
    w[7:0]   = 8'(int'(d[7:0])   & DMAX);
    return w;
  endfunction

  // Reference model: timing derived purely from elapsed cycles since reset.
  initial begin
    logic [31:0] sh [N];
    logic [31:0] ac [N];
    int unsigned ticks, pwm, frames;
    logic        tk, fe, ph, en;
    exp_t        e;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        for (int k = 0; k < N; k++) begin sh[k] = '0; ac[k] = '0; end
        mcyc = 0;
        sb.push_back('0);
      end else begin
        ticks  = mcyc / (P + 1);
        tk     = (mcyc % (P + 1)) == P;
        pwm    = ticks % (1 << B);
        frames = ticks / (1 << B);
        ph     = ((frames / BF) % 2) == 1;
        fe     = tk && (pwm == DMAX);
        e      = '0;
        for (int k = 0; k < N; k++) begin
          en = (ac[k][25:24] == 2'd1) || (ac[k][25:24] == 2'd2 && ph);
          e.rgb[3*k+2] = en && (pwm < ac[k][23:16]);
          e.rgb[3*k+1] = en && (pwm < ac[k][15:8]);
          e.rgb[3*k]   = en && (pwm < ac[k][7:0]);
        end
        e.frm = fe;
        e.rd  = (int'(addr_i) < N) ? sh[addr_i] : 32'h0;
        sb.push_back(e);
        if (we_i && int'(addr_i) < N) sh[addr_i] = stored(data_i);
        if (fe) for (int k = 0; k < N; k++) ac[k] = sh[k];
        mcyc++;
      end
    end
  end

  // Monitor: compare each registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rgb_o", 32'(rgb_o), 32'(e.rgb));
        chk("frame_o", 32'(frame_o), 32'(e.frm));
        chk("rd_data_o", rd_data_o, e.rd);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2 * FRAME_CYC + 4; i++) begin
      @(negedge clk);
      if (frame_o) return;
    end
    checks++; errors++;
    $display("FAIL frame_wait: got no frame_o pulse expected one within %0d cycles", 2 * FRAME_CYC + 4);
  endtask

  task automatic count_frame(output int r0, output int g0, output int b0, output int r1);
    r0 = 0; g0 = 0; b0 = 0; r1 = 0;
    repeat (FRAME_CYC) begin
      @(negedge clk);
      r0 += int'(rgb_o[2]); g0 += int'(rgb_o[1]); b0 += int'(rgb_o[0]); r1 += int'(rgb_o[5]);
    end
  endtask

  initial begin
    int r0, g0, b0, r1;
    cyc(3);
    rst_i = 1'b0;

    // Duty patterns on LED0
    wr(3'd0, 32'h0140_00FF);
    wait_frame();
    count_frame(r0, g0, b0, r1);
    chk("duty_red_count", 32'(r0), 32'd64);
    chk("duty_green_count", 32'(g0), 32'd0);
    chk("duty_blue_count", 32'(b0), 32'd255);

    // Mid-frame change is deferred to the next frame
    wr(3'd1, 32'h0110_0000);
    wait_frame();
    cyc(100);
    wr(3'd1, 32'h01F0_0000);
    chk("deferred_r1", 32'(rgb_o[5]), 32'd0);
    wait_frame();
    count_frame(r0, g0, b0, r1);
    chk("new_duty_r1_count", 32'(r1), 32'd240);

    // Write coinciding with frame_end is used in the frame it starts
    for (int i = 0; i < FRAME_CYC + 2; i++) begin
      if ((mcyc % FRAME_CYC) == FRAME_CYC - 1) break;
      @(negedge clk);
    end
    wr(3'd1, 32'h0120_0000);
    count_frame(r0, g0, b0, r1);
    chk("coincident_r1_count", 32'(r1), 32'd32);

    // Blink on LED0
    wr(3'd0, 32'h02FF_0000);
    cyc(6 * FRAME_CYC);

    // Address handling
    addr_i = 3'd5;
    cyc(2);
    wr(3'd5, 32'h0100_FFFF);
    addr_i = 3'd5;
    @(negedge clk);
    chk("rd_out_of_range", rd_data_o, 32'h0);
    wr(3'd1, 32'h0100_0A0B);
    addr_i = 3'd1;
    @(negedge clk);
    chk("rd_led1", rd_data_o, 32'h0100_0A0B);

    // Masking, mode 11, then steady
    wr(3'd0, 32'hFFFF_FFFF);
    addr_i = 3'd0;
    @(negedge clk);
    chk("rd_masked", rd_data_o, 32'h03FF_FFFF);
    cyc(2 * FRAME_CYC);
    wr(3'd0, 32'h01FF_FFFF);
    cyc(2 * FRAME_CYC);

    // Reset mid-frame with LED0 steady
    wr(3'd0, 32'h0180_0000);
    cyc(300);
    rst_i = 1'b1;
    cyc(2);
    rst_i = 1'b0;
    chk("reset_rgb", 32'(rgb_o), 32'h0);
    chk("reset_rd", rd_data_o, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 300);
      for (int j = 0; j < gap; j++) begin
        addr_i = 3'($urandom_range(0, 7));
        @(negedge clk);
      end
      wr(3'($urandom_range(0, 7)), $urandom);
      if (i == 20) begin
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
      end
    end

    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
